// File: rtl/renas_mem_master.sv
// renas_mem_master: AHB initiator for the clk_l2 domain.
// Turns a simple CPU/cache request into non-pipelined AHB transfers.
// An operation is a single-word read, a single-word write or a
// LINE_WORDS-beat incrementing line-fill read. Each beat holds its address
// phase until the slave answers with hreadyout=1. A per-beat watchdog aborts
// a beat that waits too long.
//
// Ports:
//   clk_l2      system clock
//   rst_n       synchronous active-low reset
//   cpu_req     request strobe, sampled only while idle
//   cpu_write   1 = write (valid with cpu_req)
//   cpu_burst   1 = line fill (ignored for writes)
//   cpu_addr    byte address, bits [1:0] ignored
//   cpu_wdata   write data, captured with cpu_req
//   cpu_busy    high while an operation is in flight
//   cpu_rvalid  one-cycle pulse per read beat, cpu_rdata valid with it
//   cpu_rlast   marks the final read beat of an operation
//   cpu_done    one-cycle pulse on successful completion
//   cpu_err     one-cycle pulse on error response or timeout
//   mem_hsel    slave select
//   mem_out     AHB master fields (haddr, htrans, hwrite, hsize, hburst, hwdata)
//   mem_in      AHB slave fields (hreadyout, hrdata, hresp)
//
// The AHB field widths come from renas_mem_pkg; DATA_LENGTH and ADDR_LENGTH
// must match them.

package renas_mem_pkg;
    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] haddr;
        logic [1:0]            htrans;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [2:0]            hburst;
        logic [AHB_DATA_W-1:0] hwdata;
    } mas_send_type;

    typedef struct packed {
        logic                  hreadyout;
        logic [AHB_DATA_W-1:0] hrdata;
        logic                  hresp;
    } slv_send_type;
endpackage

module renas_mem_master
    import renas_mem_pkg::*;
#(
    parameter int DATA_LENGTH = AHB_DATA_W,
    parameter int ADDR_LENGTH = AHB_ADDR_W,
    parameter int LINE_WORDS  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_l2,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_write,
    input  logic                   cpu_burst,
    input  logic [ADDR_LENGTH-1:0] cpu_addr,
    input  logic [DATA_LENGTH-1:0] cpu_wdata,
    output logic                   cpu_busy,
    output logic                   cpu_rvalid,
    output logic [DATA_LENGTH-1:0] cpu_rdata,
    output logic                   cpu_rlast,
    output logic                   cpu_done,
    output logic                   cpu_err,
    output logic                   mem_hsel,
    output mas_send_type           mem_out,
    input  slv_send_type           mem_in
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [ADDR_LENGTH-1:0] WORD_MASK = ~(ADDR_LENGTH'(3));
    localparam logic [ADDR_LENGTH-1:0] LINE_MASK = ~(ADDR_LENGTH'(LINE_WORDS * 4 - 1));
    localparam logic [2:0] BURST_CODE = (LINE_WORDS == 4) ? 3'b011 : 3'b001;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_WAIT = 2'b10,
        S_NEXT = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic                   write_q, write_d;
    logic                   burst_q, burst_d;
    logic                   busy_q, busy_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
    logic                   rlast_q, rlast_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   hsel_q, hsel_d;
    mas_send_type           mem_q, mem_d;
    logic                   last_beat_s;

    assign last_beat_s = !burst_q || (beat_q == LAST_BEAT);

    // Next-state and registered-output logic for the transfer FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        write_d  = write_q;
        burst_d  = burst_q;
        busy_d   = busy_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rlast_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        hsel_d   = hsel_q;
        mem_d    = mem_q;

        case (state_q)
            S_IDLE: begin
                // A request coinciding with the completion pulse is dropped;
                // the CPU has to re-assert it.
                if (cpu_req && !done_q && !err_q) begin
                    write_d       = cpu_write;
                    burst_d       = cpu_burst & ~cpu_write;
                    beat_d        = '0;
                    cnt_d         = '0;
                    busy_d        = 1'b1;
                    hsel_d        = 1'b1;
                    mem_d.haddr   = (cpu_burst && !cpu_write) ? (cpu_addr & LINE_MASK)
                                                              : (cpu_addr & WORD_MASK);
                    mem_d.htrans  = HT_NONSEQ;
                    mem_d.hwrite  = cpu_write;
                    mem_d.hsize   = 3'b010;
                    mem_d.hburst  = (cpu_burst && !cpu_write) ? BURST_CODE : 3'b000;
                    mem_d.hwdata  = cpu_wdata;
                    state_d       = S_ADDR;
                end else begin
                    busy_d        = 1'b0;
                    hsel_d        = 1'b0;
                    mem_d.htrans  = HT_IDLE;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_in.hreadyout) begin
                    if (mem_in.hresp) begin
                        err_d        = 1'b1;
                        busy_d       = 1'b0;
                        hsel_d       = 1'b0;
                        mem_d.htrans = HT_IDLE;
                        state_d      = S_IDLE;
                    end else begin
                        if (!write_q) begin
                            rvalid_d = 1'b1;
                            rdata_d  = mem_in.hrdata;
                        end else begin
                            rdata_d  = rdata_q;
                        end
                        if (last_beat_s) begin
                            rlast_d      = !write_q;
                            done_d       = 1'b1;
                            busy_d       = 1'b0;
                            hsel_d       = 1'b0;
                            mem_d.htrans = HT_IDLE;
                            state_d      = S_IDLE;
                        end else begin
                            mem_d.haddr  = mem_q.haddr + ADDR_LENGTH'(4);
                            beat_d       = beat_q + BW'(1);
                            hsel_d       = 1'b0;
                            mem_d.htrans = HT_IDLE;
                            state_d      = S_NEXT;
                        end
                    end
                end else if (cnt_q == TMO_MAX) begin
                    err_d        = 1'b1;
                    busy_d       = 1'b0;
                    hsel_d       = 1'b0;
                    mem_d.htrans = HT_IDLE;
                    state_d      = S_IDLE;
                end else begin
                    // Saturating: the TMO_MAX branch above stops the count.
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                // One deselected cycle lets the slave drop its ack first.
                hsel_d       = 1'b1;
                mem_d.htrans = HT_SEQ;
                state_d      = S_ADDR;
            end
            default: begin
                busy_d       = 1'b0;
                hsel_d       = 1'b0;
                mem_d.htrans = HT_IDLE;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_l2) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            write_q  <= 1'b0;
            burst_q  <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hsel_q   <= 1'b0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            write_q  <= write_d;
            burst_q  <= burst_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hsel_q   <= hsel_d;
            mem_q    <= mem_d;
        end
    end

    assign cpu_busy   = busy_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_rlast  = rlast_q;
    assign cpu_done   = done_q;
    assign cpu_err    = err_q;
    assign mem_hsel   = hsel_q;
    assign mem_out    = mem_q;

endmodule
